sys_id_rom_arb: RTL and testbench

- Round-robin arbiter and burst sequencer that shares one synchronous sys-id ROM read port between NUM_REQ requesters, e.g. the AXI register window and a boot-time descriptor scanner.
- Each granted request is a burst: start address plus length.
- The block issues consecutive ROM reads with address wrap-around and returns tagged data beats with a last marker.
- Sits between the ROM instance and its consumers inside the sys-id subsystem, on the up_clk domain.

---
 rtl/sys_id_pkg.sv | 21 ++
 rtl/sys_id_rr_pick.sv | 32 +++
 rtl/sys_id_rom_arb.sv | 173 +++++++++++++++++
 tb/tb_sys_id_rom_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_id_pkg.sv
// Shared types and constants for the sys-id ROM arbiter slice.
package sys_id_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ROM_ADDR_BITS_DFLT = 6;
  localparam int ROM_DEPTH_DFLT     = 1 << ROM_ADDR_BITS_DFLT;
  localparam int DRAIN_CNT_W        = 2;

  // Identification word exposed for benches and bring-up scripts.
  localparam logic [31:0] CORE_MAGIC = 32'h53594944;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_id_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr.
module sys_id_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] j;

  // Walk from lowest to highest priority so the nearest requester overwrites.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_id_rom_arb.sv
// Round-robin burst sequencer sharing one sys-id ROM read port.
// Optional running checksum output enabled by SYS_ID_ROM_ARB_CSUM_EN.
module sys_id_rom_arb
  import sys_id_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = ROM_ADDR_BITS_DFLT,
  parameter int ROM_LATENCY   = 1,
  localparam int GID_W        = idx_width(NUM_REQ),
  localparam int AW           = ROM_ADDR_BITS
) (
  input  logic                       up_clk,
  input  logic                       up_rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*AW-1:0]      req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [ROM_WIDTH-1:0]       rsp_data,
  output logic                       rsp_last,
  output logic                       busy,
  output logic [GID_W-1:0]           grant_id,
  output logic                       rom_rd_en,
  output logic [AW-1:0]              rom_rd_addr,
  input  logic [ROM_WIDTH-1:0]       rom_rd_data
`ifdef SYS_ID_ROM_ARB_CSUM_EN
  ,
  output logic [ROM_WIDTH-1:0]       rsp_csum
`endif
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(ROM_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [GID_W-1:0]        rr_ptr;
  logic [AW-1:0]           addr_q, len_q, cnt_q;
  logic [AW-1:0]           sel_addr, sel_len;
  logic [DRAIN_CNT_W-1:0]  drain_q;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [GID_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    accept, issue_last;
  logic [ROM_LATENCY-1:0]  vld_p, last_p;
  logic                    beat;

  sys_id_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_len  = req_len[i*AW +: AW];
      end
    end
  end

  // The accept pulse is masked while reset is held so every output reads 0.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    rom_rd_en  = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && up_rstn) begin
          accept    = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        rom_rd_en  = 1'b1;
        issue_last = (cnt_q == len_q);
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state    <= IDLE;
      rr_ptr   <= GID_W'(NUM_REQ - 1);
      grant_id <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr   <= pick_idx;
        grant_id <= pick_idx;
        addr_q   <= sel_addr;
        len_q    <= sel_len;
        cnt_q    <= '0;
      end else if (rom_rd_en) begin
        addr_q <= addr_q + AW'(1);
        cnt_q  <= cnt_q + AW'(1);
      end
      drain_q <= (state == DRAIN) ? drain_q + DRAIN_CNT_W'(1) : '0;
    end
  end

  // Stage p0..pN-1: valid/last flags ride alongside each outstanding ROM read.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p[0]  <= rom_rd_en;
      last_p[0] <= issue_last;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        vld_p[k]  <= vld_p[k-1];
        last_p[k] <= last_p[k-1];
      end
    end
  end

  assign beat        = vld_p[ROM_LATENCY-1];
  assign rsp_last    = beat & last_p[ROM_LATENCY-1];
  assign rsp_data    = beat ? rom_rd_data : '0;
  assign busy        = (state != IDLE);
  assign rom_rd_addr = addr_q;

  always_comb begin
    req_ready = accept ? pick_gnt : '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = beat && (grant_id == GID_W'(i));
    end
  end

`ifdef SYS_ID_ROM_ARB_CSUM_EN
  logic [ROM_WIDTH-1:0] csum_acc, csum_hold, csum_sum;

  assign csum_sum = csum_acc + rom_rd_data;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      csum_acc  <= '0;
      csum_hold <= '0;
    end else begin
      if (accept)    csum_acc <= '0;
      else if (beat) csum_acc <= csum_sum;
      if (rsp_last)  csum_hold <= csum_sum;
    end
  end

  // Live sum during beats so the final total appears alongside rsp_last.
  assign rsp_csum = beat ? csum_sum : csum_hold;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hs_chk
    a_hold_valid : assert property (@(posedge up_clk) disable iff (!up_rstn)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end

endmodule

// File: tb/tb_sys_id_rom_arb.sv
`timescale 1ns/1ps
module tb_sys_id_rom_arb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic clk = 1'b0;
  logic rstn;
  logic rom_mode;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rv1, rr1, rsv1;
  logic [11:0] ra1, rl1;
  logic [31:0] rsd1, rdata1;
  logic        rlast1, busy1, en1;
  logic [0:0]  gid1;
  logic [5:0]  raddr1;
  logic [1:0]  rv3, rr3, rsv3;
  logic [11:0] ra3, rl3;
  logic [31:0] rsd3, d3a, d3b, d3c;
  logic        rlast3, busy3, en3;
  logic [0:0]  gid3;
  logic [5:0]  raddr3;
`ifdef SYS_ID_ROM_ARB_CSUM_EN
  logic [31:0] csum1, csum3;
`endif

  function automatic logic [31:0] rom_f(input logic [5:0] a);
    if (rom_mode && a == 6'd0) return 32'd1;
    if (rom_mode && a == 6'd1) return 32'd2;
    if (rom_mode && a == 6'd2) return 32'd3;
    if (rom_mode && a == 6'd3) return 32'hFFFF_FFFF;
    return 32'h100 + {26'd0, a};
  endfunction

  always @(posedge clk) rdata1 <= rom_f(raddr1);
  always @(posedge clk) begin
    d3a <= rom_f(raddr3);
    d3b <= d3a;
    d3c <= d3b;
  end

  sys_id_rom_arb #(.NUM_REQ(2), .ROM_WIDTH(32), .ROM_ADDR_BITS(6), .ROM_LATENCY(1)) dut1 (
    .up_clk(clk), .up_rstn(rstn), .req_valid(rv1), .req_addr(ra1), .req_len(rl1),
    .req_ready(rr1), .rsp_valid(rsv1), .rsp_data(rsd1), .rsp_last(rlast1), .busy(busy1),
    .grant_id(gid1), .rom_rd_en(en1), .rom_rd_addr(raddr1), .rom_rd_data(rdata1)
`ifdef SYS_ID_ROM_ARB_CSUM_EN
    , .rsp_csum(csum1)
`endif
  );

  sys_id_rom_arb #(.NUM_REQ(2), .ROM_WIDTH(32), .ROM_ADDR_BITS(6), .ROM_LATENCY(3)) dut3 (
    .up_clk(clk), .up_rstn(rstn), .req_valid(rv3), .req_addr(ra3), .req_len(rl3),
    .req_ready(rr3), .rsp_valid(rsv3), .rsp_data(rsd3), .rsp_last(rlast3), .busy(busy3),
    .grant_id(gid3), .rom_rd_en(en3), .rom_rd_addr(raddr3), .rom_rd_data(d3c)
`ifdef SYS_ID_ROM_ARB_CSUM_EN
    , .rsp_csum(csum3)
`endif
  );

  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    bad++;
    $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic pos1();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    int wa [4];
    int k, last_cyc, nbeat;
    logic [1:0]  bv;
    logic [31:0] bd;
    wa = '{62, 63, 0, 1};
    rstn = 1'b0; rom_mode = 1'b0;
    rv1 = '0; ra1 = '0; rl1 = '0;
    rv3 = '0; ra3 = '0; rl3 = '0;
    repeat (2) @(posedge clk);
    neg();
    total++; if (busy1 !== 1'b0) fail("rst_busy", busy1, 1'b0);
    total++; if (en1 !== 1'b0) fail("rst_en", en1, 1'b0);
    total++; if (rsv1 !== 2'b00) fail("rst_rsv", rsv1, 2'b00);
    total++; if (gid1 !== 1'b0) fail("rst_gid", gid1, 1'b0);
    total++; if (rr1 !== 2'b00) fail("rst_ready", rr1, 2'b00);
    total++; if (raddr1 !== 6'd0) fail("rst_addr", raddr1, 6'd0);
    total++; if (busy3 !== 1'b0) fail("rst_busy3", busy3, 1'b0);
    pos1(); rstn = 1'b1;

    pos1(); rv1 = 2'b01; ra1 = {6'd0, 6'd4}; rl1 = {6'd0, 6'd2};
    neg();
    total++; if (rr1 !== 2'b01) fail("t1_ready", rr1, 2'b01);
    pos1(); rv1 = 2'b00;
    neg();
    total++; if (busy1 !== 1'b1) fail("t1_c1_busy", busy1, 1'b1);
    total++; if (en1 !== 1'b1) fail("t1_c1_en", en1, 1'b1);
    total++; if (raddr1 !== 6'd4) fail("t1_c1_addr", raddr1, 6'd4);
    total++; if (rsv1 !== 2'b00) fail("t1_c1_rsv", rsv1, 2'b00);
    for (int c = 2; c <= 4; c++) begin
      pos1(); neg();
      total++; if (rsv1 !== 2'b01) fail("t1_beat_vld", rsv1, 2'b01);
      total++; if (rsd1 !== 32'(32'h100 + c + 2)) fail("t1_beat_data", rsd1, 32'h100 + c + 2);
      total++; if (rlast1 !== (c == 4)) fail("t1_beat_last", rlast1, (c == 4));
    end
    total++; if (busy1 !== 1'b1) fail("t1_drain_busy", busy1, 1'b1);
    total++; if (en1 !== 1'b0) fail("t1_drain_en", en1, 1'b0);
    pos1(); neg();
    total++; if (busy1 !== 1'b0) fail("t1_idle_busy", busy1, 1'b0);
    total++; if (rsv1 !== 2'b00) fail("t1_idle_rsv", rsv1, 2'b00);

    pos1(); rv1 = 2'b10; ra1 = {6'd62, 6'd0}; rl1 = {6'd3, 6'd0};
    neg();
    total++; if (rr1 !== 2'b10) fail("t2_ready", rr1, 2'b10);
    for (int c = 1; c <= 5; c++) begin
      pos1();
      if (c == 1) rv1 = 2'b00;
      neg();
      if (c == 1) begin
        total++; if (gid1 !== 1'b1) fail("t2_gid", gid1, 1'b1);
      end
      if (c <= 4) begin
        total++; if (en1 !== 1'b1) fail("t2_en", en1, 1'b1);
        total++; if (raddr1 !== 6'(wa[c-1])) fail("t2_rd_addr", raddr1, 6'(wa[c-1]));
      end
      if (c >= 2) begin
        total++; if (rsv1 !== 2'b10) fail("t2_beat_vld", rsv1, 2'b10);
        total++; if (rsd1 !== 32'(32'h100 + wa[c-2])) fail("t2_beat_data", rsd1, 32'h100 + wa[c-2]);
        total++; if (rlast1 !== (c == 5)) fail("t2_beat_last", rlast1, (c == 5));
      end
    end
    pos1(); neg();
    total++; if (busy1 !== 1'b0) fail("t2_idle_busy", busy1, 1'b0);

    pos1(); rstn = 1'b0; rv1 = 2'b11; ra1 = {6'd8, 6'd0}; rl1 = '0;
    #1;
    total++; if (rr1 !== 2'b00) fail("t3_rst_ready", rr1, 2'b00);
    total++; if (busy1 !== 1'b0) fail("t3_rst_busy", busy1, 1'b0);
    pos1(); rstn = 1'b1;
    neg();
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) neg();
      bv = '0; bd = '0; k = 0;
      while (rr1 == 2'b00 && k < 8) begin
        if (rsv1 != 2'b00) begin bv = rsv1; bd = rsd1; end
        neg(); k++;
      end
      total++; if (rr1 !== ((g % 2) ? 2'b10 : 2'b01)) fail("t3_grant", rr1, ((g % 2) ? 2'b10 : 2'b01));
      if (g > 0) begin
        total++; if ((cyc - last_cyc) !== 3) fail("t3_gap", cyc - last_cyc, 3);
        total++; if (bv !== ((g % 2) ? 2'b01 : 2'b10)) fail("t3_prev_owner", bv, ((g % 2) ? 2'b01 : 2'b10));
        total++; if (bd !== ((g % 2) ? 32'h100 : 32'h108)) fail("t3_prev_data", bd, ((g % 2) ? 32'h100 : 32'h108));
      end
      last_cyc = cyc;
    end
    pos1(); rv1 = 2'b01;
    neg();
    bv = '0; bd = '0; k = 0;
    while (rr1 == 2'b00 && k < 8) begin
      if (rsv1 != 2'b00) begin bv = rsv1; bd = rsd1; end
      neg(); k++;
    end
    total++; if (bv !== 2'b10) fail("t3_last_owner", bv, 2'b10);
    total++; if (bd !== 32'h108) fail("t3_last_data", bd, 32'h108);
    total++; if (rr1 !== 2'b01) fail("t3_tail_grant", rr1, 2'b01);
    pos1(); rv1 = 2'b00;
    repeat (4) pos1();

    rv1 = 2'b10; ra1 = {6'd16, 6'd0}; rl1 = {6'd7, 6'd0};
    neg();
    total++; if (rr1 !== 2'b10) fail("t5_ready", rr1, 2'b10);
    pos1(); rv1 = 2'b00;
    pos1(); neg();
    total++; if (rsd1 !== 32'h110) fail("t5_beat1", rsd1, 32'h110);
    pos1(); neg();
    total++; if (rsv1 !== 2'b10) fail("t5_beat2_vld", rsv1, 2'b10);
    total++; if (rsd1 !== 32'h111) fail("t5_beat2", rsd1, 32'h111);
    #1 rstn = 1'b0;
    #1;
    total++; if (rsv1 !== 2'b00) fail("t5_rst_rsv", rsv1, 2'b00);
    total++; if (busy1 !== 1'b0) fail("t5_rst_busy", busy1, 1'b0);
    total++; if (en1 !== 1'b0) fail("t5_rst_en", en1, 1'b0);
    total++; if (rsd1 !== 32'h0) fail("t5_rst_data", rsd1, 32'h0);
    total++; if (rlast1 !== 1'b0) fail("t5_rst_last", rlast1, 1'b0);
    total++; if (gid1 !== 1'b0) fail("t5_rst_gid", gid1, 1'b0);
    total++; if (raddr1 !== 6'd0) fail("t5_rst_addr", raddr1, 6'd0);
    pos1(); pos1(); rstn = 1'b1;
    nbeat = 0;
    for (int c = 0; c < 4; c++) begin
      neg();
      if (rsv1 != 2'b00) nbeat++;
      pos1();
    end
    total++; if (nbeat !== 0) fail("t5_no_beats", nbeat, 0);
    rv1 = 2'b11; ra1 = {6'd9, 6'd3}; rl1 = '0;
    neg();
    total++; if (rr1 !== 2'b01) fail("t5_req0_first", rr1, 2'b01);
    pos1(); rv1 = 2'b10;
    neg();
    k = 0;
    while (rr1 == 2'b00 && k < 8) begin neg(); k++; end
    total++; if (rr1 !== 2'b10) fail("t5_req1_next", rr1, 2'b10);
    pos1(); rv1 = 2'b00;

    pos1(); rv3 = 2'b01; ra3 = {6'd0, 6'd5}; rl3 = '0;
    neg();
    total++; if (rr3 !== 2'b01) fail("t4_ready", rr3, 2'b01);
    pos1(); rv3 = 2'b10; ra3 = {6'd7, 6'd5};
    neg();
    total++; if (en3 !== 1'b1) fail("t4_c1_en", en3, 1'b1);
    total++; if (rr3 !== 2'b00) fail("t4_c1_ready", rr3, 2'b00);
    for (int c = 2; c <= 3; c++) begin
      pos1(); neg();
      total++; if (busy3 !== 1'b1) fail("t4_drain_busy", busy3, 1'b1);
      total++; if (rsv3 !== 2'b00) fail("t4_drain_rsv", rsv3, 2'b00);
    end
    pos1(); neg();
    total++; if (rsv3 !== 2'b01) fail("t4_beat_vld", rsv3, 2'b01);
    total++; if (rsd3 !== 32'h105) fail("t4_beat_data", rsd3, 32'h105);
    total++; if (rlast3 !== 1'b1) fail("t4_beat_last", rlast3, 1'b1);
    total++; if (rr3 !== 2'b00) fail("t4_c4_ready", rr3, 2'b00);
    pos1(); neg();
    total++; if (busy3 !== 1'b0) fail("t4_c5_busy", busy3, 1'b0);
    total++; if (rr3 !== 2'b10) fail("t4_c5_ready", rr3, 2'b10);
    pos1(); rv3 = 2'b00;
    repeat (8) pos1();

`ifdef SYS_ID_ROM_ARB_CSUM_EN
    rom_mode = 1'b1;
    rv1 = 2'b01; ra1 = {6'd0, 6'd0}; rl1 = {6'd0, 6'd3};
    neg();
    total++; if (rr1 !== 2'b01) fail("t6_ready", rr1, 2'b01);
    for (int c = 1; c <= 5; c++) begin
      pos1();
      if (c == 1) rv1 = 2'b00;
      neg();
    end
    total++; if (rlast1 !== 1'b1) fail("t6_last", rlast1, 1'b1);
    total++; if (csum1 !== 32'h5) fail("t6_csum", csum1, 32'h5);
    pos1(); neg();
    total++; if (csum1 !== 32'h5) fail("t6_csum_hold", csum1, 32'h5);
    rom_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
